// File: rtl/div_req_scheduler.sv
// div_req_scheduler
//   Two requesters share one iterative restoring divider. A round-robin arbiter
//   picks the next operation while idle. The divider produces one quotient bit
//   per clock. The result is returned on a valid/ready port, tagged with the
//   ID of the requester that owns it.
//   Optional feature macro: DIV_ZERO_BYPASS_EN. When it is defined, a zero
//   divisor skips the iterative steps. The result values are the same; only
//   the latency is shorter.
module div_req_scheduler #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [VW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [VW-1:0] req1_b,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_id,
  output logic [DW-1:0] resp_q,
  output logic [VW-1:0] resp_r,
  output logic          resp_dz
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          rr_last;
  logic          grant1;
  logic          accept;
  logic          bypass;
  logic [DW-1:0] acc_a;
  logic [VW-1:0] acc_b;
  logic          acc_zero;

  logic [DW-1:0] q_reg;
  logic [VW-1:0] r_reg;
  logic [VW-1:0] b_reg;
  logic          id_reg;
  logic          dz_reg;
  logic [CW-1:0] cnt;

  logic [VW:0]   r_sh;
  logic [VW:0]   t_diff;
  logic          take;
  logic [VW-1:0] r_step;
  logic [DW-1:0] q_step;

  // Arbitration: a lone request wins outright; a tie goes to the requester that did not win last
  always_comb begin
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (req0_valid && req1_valid) begin
      grant1 = ~rr_last;
    end else begin
      grant1 = req1_valid;
    end
    if (state == IDLE) begin
      req0_ready = req0_valid & ~grant1;
      req1_ready = req1_valid & grant1;
    end
  end

  assign accept   = req0_ready | req1_ready;
  assign acc_a    = grant1 ? req1_a : req0_a;
  assign acc_b    = grant1 ? req1_b : req0_b;
  assign acc_zero = (acc_b == '0);

`ifdef DIV_ZERO_BYPASS_EN
  assign bypass = accept & acc_zero;
`else
  assign bypass = 1'b0;
`endif

  // One restoring step: shift {R,Q} left, trial-subtract the divisor, keep the difference if it is non-negative.
  // R is stored as VW bits: after a nonzero-divisor step R < b, and its top bit would be dropped by the next shift anyway.
  // A zero divisor always restores, so the quotient fills with ones and R carries the low bits of a.
  always_comb begin
    r_sh   = {r_reg, q_reg[DW-1]};
    t_diff = r_sh - {1'b0, b_reg};
    take   = ~t_diff[VW] | dz_reg;
    r_step = take ? t_diff[VW-1:0] : r_sh[VW-1:0];
    q_step = {q_reg[DW-2:0], take};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept -> iterate DW steps -> hold the result until the consumer takes it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = bypass ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CW'(DW - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (resp_valid && resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath and response registers. The response is loaded on the first DONE cycle and cleared when it retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last    <= 1'b1;
      q_reg      <= '0;
      r_reg      <= '0;
      b_reg      <= '0;
      id_reg     <= 1'b0;
      dz_reg     <= 1'b0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_q     <= '0;
      resp_r     <= '0;
      resp_dz    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr_last <= grant1;
            id_reg  <= grant1;
            b_reg   <= acc_b;
            dz_reg  <= acc_zero;
            cnt     <= '0;
            if (bypass) begin
              q_reg <= '1;
              r_reg <= acc_a[VW-1:0];
            end else begin
              q_reg <= acc_a;
              r_reg <= '0;
            end
          end
        end
        CALC: begin
          q_reg <= q_step;
          r_reg <= r_step;
          cnt   <= cnt + CW'(1);
        end
        DONE: begin
          if (!resp_valid) begin
            resp_valid <= 1'b1;
            resp_id    <= id_reg;
            resp_q     <= q_reg;
            resp_r     <= r_reg;
            resp_dz    <= dz_reg;
          end else if (resp_ready) begin
            resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_req_scheduler.sv
// tb_div_req_scheduler
//   Randomized bench for the shared divider scheduler. The driver predicts the
//   round-robin winner and pushes the expected result, computed with plain
//   integer division, into a scoreboard queue. A separate monitor checks each
//   response as it retires. It also checks response latency, that data stays
//   stable while a response is stalled, and that no request is accepted while
//   a response is pending.
module tb_div_req_scheduler;

  localparam int DW = 8;
  localparam int VW = 4;

  typedef struct {
    logic          id;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dz;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready;
  logic [DW-1:0] req0_a;
  logic [VW-1:0] req0_b;
  logic          req1_valid, req1_ready;
  logic [DW-1:0] req1_a;
  logic [VW-1:0] req1_b;
  logic          resp_valid, resp_ready;
  logic          resp_id;
  logic [DW-1:0] resp_q;
  logic [VW-1:0] resp_r;
  logic          resp_dz;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  bit            pend[2];
  logic [DW-1:0] pa[2];
  logic [VW-1:0] pb[2];
  int            lastGrant = 1;

  logic          prevValid = 1'b0;
  logic          prevTaken = 1'b0;
  logic [DW+VW+1:0] prevData = '0;

  div_req_scheduler #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_q(resp_q), .resp_r(resp_r), .resp_dz(resp_dz)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result from arithmetic on the operands alone
  function automatic exp_t model(input int a, input int b, input logic id, input int acc);
    exp_t e;
    e.id  = id;
    e.acc = acc;
    if (b == 0) begin
      e.q  = DW'((1 << DW) - 1);
      e.r  = VW'(a % (1 << VW));
      e.dz = 1'b1;
    end else begin
      e.q  = DW'(a / b);
      e.r  = VW'(a % b);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Consumer: mostly ready, with occasional long stalls
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 9) == 0) begin
        resp_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on first assertion, stability while stalled, no accepts while pending, scoreboard on retire
  initial begin
    int latWant;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 1'b0;
        prevTaken = 1'b0;
      end else begin
        if (resp_valid) begin
          total++;
          if (req0_ready || req1_ready) begin
            bad++;
            $display("[TB] FAIL ready_while_pending got=%b%b want=00", req0_ready, req1_ready);
          end
          if (!prevValid) begin
            total++;
            if (sb.size() == 0) begin
              bad++;
              $display("[TB] FAIL unexpected_resp got id=%0d q=%0d r=%0d want none", resp_id, resp_q, resp_r);
            end else begin
              latWant = DW + 1;
`ifdef DIV_ZERO_BYPASS_EN
              if (sb[0].dz) latWant = 1;
`endif
              if (cyc - sb[0].acc != latWant) begin
                bad++;
                $display("[TB] FAIL latency got=%0d want=%0d", cyc - sb[0].acc, latWant);
              end
            end
          end else if (!prevTaken) begin
            total++;
            if ({resp_id, resp_q, resp_r, resp_dz} != prevData) begin
              bad++;
              $display("[TB] FAIL stall_stable got=%h want=%h", {resp_id, resp_q, resp_r, resp_dz}, prevData);
            end
          end
          if (resp_ready && sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (resp_id !== e.id || resp_q !== e.q || resp_r !== e.r || resp_dz !== e.dz) begin
              bad++;
              $display("[TB] FAIL result got id=%0d q=%0d r=%0d dz=%0d want id=%0d q=%0d r=%0d dz=%0d",
                       resp_id, resp_q, resp_r, resp_dz, e.id, e.q, e.r, e.dz);
            end
          end
        end
        prevValid = resp_valid;
        prevTaken = resp_valid & resp_ready;
        prevData  = {resp_id, resp_q, resp_r, resp_dz};
      end
    end
  end

  task automatic checkOutput(input string name);
    logic [DW+VW+3:0] got;
    got = {resp_valid, resp_id, resp_q, resp_r, resp_dz, req0_ready, req1_ready};
    total++;
    if (got !== '0) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=0", name, got);
    end
  endtask

  task automatic driveReqs();
    req0_valid = pend[0]; req0_a = pa[0]; req0_b = pb[0];
    req1_valid = pend[1]; req1_a = pa[1]; req1_b = pb[1];
  endtask

  // Presents the pending requests, waits for the predicted winner to be accepted, queues its expected result
  task automatic applyStimulus(output bit ok);
    int  w;
    bit  seen;
    driveReqs();
    if (pend[0] && pend[1]) w = (lastGrant == 1) ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL grant_timeout got=none want=req%0d", w);
      ok = 0;
      return;
    end
    if (req0_ready !== (w == 0) || req1_ready !== (w == 1)) begin
      bad++;
      $display("[TB] FAIL grant got=%b%b want=req%0d", req0_ready, req1_ready, w);
    end
    sb.push_back(model(int'(pa[w]), int'(pb[w]), w[0], cyc + 1));
    @(posedge clk);
    #1;
    pend[w]   = 0;
    lastGrant = w;
    driveReqs();
    ok = 1;
  endtask

  task automatic newOp(input int i);
    pend[i] = 1;
    pa[i]   = DW'($urandom_range(0, (1 << DW) - 1));
    pb[i]   = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom_range(1, (1 << VW) - 1));
  endtask

  task automatic directed(input int id, input int a, input int b, output bit ok);
    pend[id] = 1;
    pa[id]   = DW'(a);
    pb[id]   = VW'(b);
    applyStimulus(ok);
  endtask

  task automatic drainScoreboard();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain got=%0d pending want=0", sb.size());
    end
  endtask

  initial begin
    bit ok;
    ok = 1;
    rst_n = 1'b0;
    pend[0] = 0; pend[1] = 0;
    pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0;
    driveReqs();
    #12;
    checkOutput("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases, one requester at a time
    if (ok) directed(0, 48, 3, ok);
    if (ok) directed(1, 64, 6, ok);
    if (ok) directed(1, 192, 12, ok);
    if (ok) directed(0, 0, 0, ok);
    if (ok) directed(1, 255, 1, ok);
    if (ok) directed(0, 255, 15, ok);

    // Both requesters always valid: grants must alternate
    for (int n = 0; n < 6 && ok; n++) begin
      if (!pend[0]) newOp(0);
      if (!pend[1]) newOp(1);
      applyStimulus(ok);
    end

    // Random mix of single and simultaneous requests
    for (int n = 0; n < 50 && ok; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) newOp(i);
      end
      if (!pend[0] && !pend[1]) newOp(int'($urandom_range(0, 1)));
      applyStimulus(ok);
    end

    // Flush any request still held by the loser of the last tie
    while (ok && (pend[0] || pend[1])) applyStimulus(ok);
    if (ok) drainScoreboard();

    // Reset in the middle of a calculation must abort it with no response
    if (ok) begin
      directed(0, 200, 7, ok);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_midcalc");
      sb.delete();
      lastGrant = 1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < DW + 4; i++) begin
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL stale_resp got=%b want=0", resp_valid);
        end
      end
      @(posedge clk);
      #1;
    end

    // Operation resumes after reset, including a tie that must again go to requester 0 first
    if (ok) directed(1, 100, 9, ok);
    if (ok) begin
      pend[0] = 1; pa[0] = 8'd77; pb[0] = 4'd5;
      pend[1] = 1; pa[1] = 8'd13; pb[1] = 4'd0;
      applyStimulus(ok);
    end
    if (ok) applyStimulus(ok);
    if (ok) drainScoreboard();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
